// File: rtl/cpu_pkg.sv
// Shared CPU types: opcode encoding, default fetch widths and fetch FSM states.
package cpu_pkg;

  localparam int OPC_W      = 3;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  // Opcode encoding; 1 is unused.
  typedef enum logic [OPC_W-1:0] {
    HALT = 3'd0,
    SKZ  = 3'd2,
    ADD  = 3'd3,
    AND  = 3'd4,
    LDA  = 3'd5,
    STO  = 3'd6,
    JMP  = 3'd7
  } opcode_e;

  // Fetch FSM states. HALTED is only left through reset.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/program_counter.sv
// Program counter: increment / jump mux with a registered wrap pulse.
module program_counter
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,      // freeze the PC this cycle (halt)
  input  logic              pc_en,
  input  logic              pc_load,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_wrap
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              wrap_q, wrap_d;

  // Next PC: a taken jump beats any increment; a skip or pc_en both increment.
  // Only the increment path can raise the wrap pulse.
  always_comb begin
    pc_d   = pc_q;
    wrap_d = 1'b0;
    if (!hold) begin
      if (pc_load && jmp) begin
        pc_d = load_val;
      end else if (pc_load || pc_en) begin
        pc_d   = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        wrap_d = &pc_q;
      end
    end
  end

  // PC and wrap-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= '0;
      wrap_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      wrap_q <= wrap_d;
    end
  end

  assign pc      = pc_q;
  assign pc_wrap = wrap_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the IR and the req/ack handshake to
// instruction memory, and applies the controller's PC and halt commands.
// Every output is driven straight from a register.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic              pc_en,
  input  logic              pc_load,
  input  logic              jmp,
  input  logic              halt_in,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [OPC_W-1:0]  opcode,
  output logic [ADDR_W-1:0] operand,
  output logic              ir_valid,
  output logic              busy,
  output logic              halted,
  output logic              fetch_overrun,
  output logic              pc_wrap
);

  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              overrun_q, overrun_d;
  logic              pc_hold;

  // Halt takes effect in the same cycle it is raised, so the PC freezes then too.
  assign pc_hold = halt_in || (state_q == HALTED);

  program_counter #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .hold     (pc_hold),
    .pc_en    (pc_en),
    .pc_load  (pc_load),
    .jmp      (jmp),
    .load_val (ir_q[ADDR_W-1:0]),
    .pc       (pc),
    .pc_wrap  (pc_wrap)
  );

  // Fetch FSM next state. The fetch latches the pre-update PC, and an ack seen
  // in IDLE (including one alongside fetch_req) is never captured.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    addr_d     = addr_q;
    overrun_d  = overrun_q;
    case (state_q)
      IDLE: begin
        if (halt_in) begin
          state_d = HALTED;
        end else if (fetch_req) begin
          state_d    = REQ;
          addr_d     = pc;
          ir_valid_d = 1'b0;
        end
      end
      REQ: begin
        if (halt_in) begin
          state_d = HALTED;
        end else begin
          if (fetch_req) begin
            overrun_d = 1'b1;
          end
          if (imem_ack) begin
            state_d    = IDLE;
            ir_d       = imem_rdata;
            ir_valid_d = 1'b1;
          end
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM, IR and handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      addr_q     <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      addr_q     <= addr_d;
      overrun_q  <= overrun_d;
    end
  end

  assign imem_addr     = addr_q;
  assign imem_req      = (state_q == REQ);
  assign busy          = (state_q == REQ);
  assign halted        = (state_q == HALTED);
  assign fetch_overrun = overrun_q;
  assign ir_valid      = ir_valid_q;
  assign opcode        = ir_q[DATA_W-1 -: OPC_W];
  assign operand       = ir_q[ADDR_W-1:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. Inputs change and outputs are checked
// 1 ns after each rising edge.
module tb_instr_fetch;
  import cpu_pkg::*;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              fetch_req, pc_en, pc_load, jmp, halt_in;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_req;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic [ADDR_W-1:0] pc;
  logic [OPC_W-1:0]  opcode;
  logic [ADDR_W-1:0] operand;
  logic              ir_valid, busy, halted, fetch_overrun, pc_wrap;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_fetch #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_req     (fetch_req),
    .pc_en         (pc_en),
    .pc_load       (pc_load),
    .jmp           (jmp),
    .halt_in       (halt_in),
    .imem_addr     (imem_addr),
    .imem_req      (imem_req),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .pc            (pc),
    .opcode        (opcode),
    .operand       (operand),
    .ir_valid      (ir_valid),
    .busy          (busy),
    .halted        (halted),
    .fetch_overrun (fetch_overrun),
    .pc_wrap       (pc_wrap)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    fetch_req  = 1'b0;
    pc_en      = 1'b0;
    pc_load    = 1'b0;
    jmp        = 1'b0;
    halt_in    = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 8'h00;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_pc", 32'(pc), 0);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_ir_valid", 32'(ir_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_overrun", 32'(fetch_overrun), 0);
    chk("rst_wrap", 32'(pc_wrap), 0);
    chk("rst_opcode", 32'(opcode), 0);

    // Stray ack with nothing outstanding is ignored
    imem_ack = 1'b1; imem_rdata = 8'hA3;
    step();
    chk("stray_ack_valid", 32'(ir_valid), 0);
    chk("stray_ack_opc", 32'(opcode), 0);

    // fetch_req together with ack in IDLE: new request, ack not captured
    fetch_req = 1'b1; imem_ack = 1'b1; imem_rdata = 8'hFF;
    step();
    fetch_req = 1'b0; imem_ack = 1'b0;
    chk("f1_req", 32'(imem_req), 1);
    chk("f1_busy", 32'(busy), 1);
    chk("f1_addr", 32'(imem_addr), 0);
    chk("f1_not_captured", 32'(ir_valid), 0);
    imem_ack = 1'b1; imem_rdata = 8'hA3;
    step();
    idle_inputs();
    chk("f1_valid", 32'(ir_valid), 1);
    chk("f1_opcode", 32'(opcode), 5);
    chk("f1_operand", 32'(operand), 3);
    chk("f1_req_drop", 32'(imem_req), 0);
    chk("f1_busy_drop", 32'(busy), 0);

    // Count PC up to 5, then fetch JMP 12 there
    pc_en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    pc_en = 1'b0;
    chk("pc_5", 32'(pc), 5);
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("f2_addr", 32'(imem_addr), 5);
    imem_ack = 1'b1; imem_rdata = 8'hEC;
    step();
    idle_inputs();
    chk("f2_opcode", 32'(opcode), 7);
    chk("f2_operand", 32'(operand), 12);
    chk("f2_pc_hold", 32'(pc), 5);

    // Jump, skip, and jump beating pc_en
    pc_load = 1'b1; jmp = 1'b1;
    step();
    chk("jmp_pc", 32'(pc), 12);
    jmp = 1'b0;
    step();
    chk("skip_pc", 32'(pc), 13);
    jmp = 1'b1; pc_en = 1'b1;
    step();
    idle_inputs();
    chk("load_prio_pc", 32'(pc), 12);

    // fetch_req with pc_en: fetch uses old PC, PC still advances
    fetch_req = 1'b1; pc_en = 1'b1;
    step();
    idle_inputs();
    chk("f3_addr_prepc", 32'(imem_addr), 12);
    chk("f3_pc_inc", 32'(pc), 13);
    imem_ack = 1'b1; imem_rdata = 8'hFF;
    step();
    idle_inputs();
    chk("f3_operand", 32'(operand), 31);

    // Jump to 31, then increment wraps to 0 with a one-cycle pulse
    pc_load = 1'b1; jmp = 1'b1;
    step();
    idle_inputs();
    chk("pc_31", 32'(pc), 31);
    chk("jmp31_nowrap", 32'(pc_wrap), 0);
    pc_en = 1'b1;
    step();
    pc_en = 1'b0;
    chk("wrap_pc", 32'(pc), 0);
    chk("wrap_pulse", 32'(pc_wrap), 1);
    step();
    chk("wrap_pulse_end", 32'(pc_wrap), 0);

    // Fetch JMP 0, count to 31, jump to 0: no wrap pulse
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    imem_ack = 1'b1; imem_rdata = 8'hE0;
    step();
    idle_inputs();
    chk("f4_operand", 32'(operand), 0);
    pc_en = 1'b1;
    for (int i = 0; i < 31; i++) step();
    pc_en = 1'b0;
    chk("count_31", 32'(pc), 31);
    pc_load = 1'b1; jmp = 1'b1;
    step();
    idle_inputs();
    chk("jmp0_pc", 32'(pc), 0);
    chk("jmp0_nowrap", 32'(pc_wrap), 0);

    // Ack delayed 4 cycles with a second fetch_req during the wait
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    imem_rdata = 8'h99;
    for (int i = 0; i < 4; i++) begin
      chk("wait_req", 32'(imem_req), 1);
      chk("wait_addr", 32'(imem_addr), 0);
      chk("wait_busy", 32'(busy), 1);
      fetch_req = (i == 1);
      step();
    end
    fetch_req = 1'b0;
    chk("overrun_set", 32'(fetch_overrun), 1);
    imem_ack = 1'b1; imem_rdata = 8'h45;
    step();
    idle_inputs();
    chk("f5_opcode", 32'(opcode), 2);
    chk("f5_operand", 32'(operand), 5);
    chk("f5_valid", 32'(ir_valid), 1);
    step();
    chk("f5_no_refetch", 32'(imem_req), 0);
    chk("overrun_sticky", 32'(fetch_overrun), 1);

    // Halt during REQ, then everything else is ignored
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    halt_in = 1'b1;
    step();
    halt_in = 1'b0;
    chk("halt_req", 32'(imem_req), 0);
    chk("halt_flag", 32'(halted), 1);
    chk("halt_busy", 32'(busy), 0);
    pc_en = 1'b1; fetch_req = 1'b1; imem_ack = 1'b1; imem_rdata = 8'hEC;
    step();
    step();
    idle_inputs();
    chk("halt_pc_frozen", 32'(pc), 0);
    chk("halt_no_fetch", 32'(imem_req), 0);
    chk("halt_ir_frozen", 32'(operand), 5);
    chk("halt_valid", 32'(ir_valid), 0);
    chk("halt_sticky", 32'(halted), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_clr_halt", 32'(halted), 0);
    chk("rst_clr_pc", 32'(pc), 0);

    // Reset mid-fetch, late ack afterwards is ignored
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("f6_req", 32'(imem_req), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    imem_ack = 1'b1; imem_rdata = 8'hA3;
    step();
    idle_inputs();
    chk("late_ack_valid", 32'(ir_valid), 0);
    chk("late_ack_opc", 32'(opcode), 0);
    chk("late_ack_operand", 32'(operand), 0);
    chk("late_ack_req", 32'(imem_req), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage that sits directly upstream of the CPU control FSM. It holds the program counter (PC) and instruction register (IR), and fetches from instruction memory over a req/ack handshake when the control FSM requests it. It supplies opcode and operand to the controller and datapath, and applies the controller's PC-increment, PC-load (jump/skip) and halt commands.

Parameters:
ADDR_W, 5, PC / instruction-memory address width
DATA_W, 8, instruction width; opcode = IR[DATA_W-1:DATA_W-3], operand = IR[ADDR_W-1:0]
OPC_W, 3, opcode width (fixed by package, not overridden)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
fetch_req  in  1  start fetch at current PC (one-cycle pulse from controller fetch state)
pc_en  in  1  PC <= PC+1
pc_load  in  1  PC load command
jmp  in  1  qualifies pc_load: 1 = load operand, 0 = skip (PC+1)
halt_in  in  1  halt command from controller
imem_addr  out  ADDR_W  instruction memory address (registered)
imem_req  out  1  memory request, held until ack
imem_ack  in  1  memory returns imem_rdata this cycle
imem_rdata  in  DATA_W  instruction word
pc  out  ADDR_W  current PC
opcode  out  OPC_W  IR opcode field
operand  out  ADDR_W  IR operand field
ir_valid  out  1  IR holds a completed fetch
busy  out  1  fetch in progress
halted  out  1  halted, sticky until rst
fetch_overrun  out  1  sticky: fetch_req arrived while busy
pc_wrap  out  1  one-cycle pulse when increment wraps from all-ones to 0

Behaviour:
- Reset: pc=0, IR=0, imem_addr=0, imem_req=0, ir_valid=0, busy=0, halted=0, fetch_overrun=0, pc_wrap=0, state=IDLE. IR=0 decodes as HALT, so consumers must qualify with ir_valid.
- FSM states:
  - IDLE -> REQ on fetch_req. On entry: imem_addr <= pc, imem_req <= 1, busy <= 1, ir_valid <= 0.
  - REQ: hold imem_req and imem_addr stable. On imem_ack: IR <= imem_rdata, imem_req <= 0, busy <= 0, ir_valid <= 1, -> IDLE.
  - Minimum latency: ack in the cycle after request, giving IR valid 2 cycles after fetch_req.
  - HALTED: entered from any state when halt_in=1. Drops imem_req, busy=0, halted=1. Exits only on rst.
- Ack timing: ack with no request outstanding is ignored. A same-cycle fetch_req+ack in IDLE is treated as a new request only; the ack is not captured.
- fetch_req while in REQ: ignored, fetch_overrun <= 1.
- PC update, evaluated every non-halted cycle:
  - pc_load && jmp: pc <= operand.
  - pc_load && !jmp: pc <= pc+1.
  - else pc_en: pc <= pc+1.
  - pc_load has priority over pc_en.
  - Increments are mod 2^ADDR_W; pc_wrap pulses when pc goes from all-ones to 0 by increment, not by jump.
- fetch_req and a PC update in the same cycle: the fetch uses the pre-update PC; the PC still updates.
- halt_in same cycle as other inputs: halt wins; no PC update, no fetch starts; IR and pc are frozen.
- rst mid-fetch: request dropped next edge; the late ack after reset is ignored (state IDLE).
- No combinational path from inputs to outputs.

Decomposition:
- cpu_pkg: OPC_W, opcode enum (HALT=0, SKZ=2, ADD=3, AND=4, LDA=5, STO=6, JMP=7), default ADDR_W/DATA_W, fetch state enum {IDLE, REQ, HALTED}.
- One sub-module, program_counter: pc register, increment/load mux, pc_wrap.
- instr_fetch holds the FSM, IR and handshake.

Test Plan:
- Reset then fetch_req with mem[0]=8'hA3, ack 1 cycle later -> opcode=5, operand=3, ir_valid=1 two cycles after fetch_req; imem_addr=0.
- pc=5, pc_load=1, jmp=1, IR operand=12 -> pc=12 next cycle; pc_load=1, jmp=0 at pc=12 -> pc=13; pc_en+pc_load(jmp=1) together -> pc=operand.
- pc=31, pc_en -> pc=0, pc_wrap high exactly one cycle; jump to 0 from 31 -> pc_wrap stays 0.
- Ack delayed 4 cycles -> imem_req and imem_addr stable all 4 cycles, busy=1; second fetch_req mid-wait -> fetch_overrun=1, IR from the first fetch only.
- halt_in mid-REQ -> imem_req=0, halted=1 next cycle; later pc_en, fetch_req and ack have no effect; rst clears halted and sets pc=0.
- rst asserted during REQ, ack arrives the cycle after -> ir_valid stays 0, IR=0.
